// File: rtl/lighthouse_pulse_decoder.sv
// lighthouse_pulse_decoder: per-photodiode front end for lighthouse tracking.
// Synchronises the raw sensor envelope, measures each light pulse in
// microseconds, classifies it as sync or sweep, decodes sync codes and
// time-stamps sweeps against the latest non-skip sync.
// Optional feature macro: LIGHTHOUSE_OOTX_EN (OOTX data-bit shift registers).
module lighthouse_pulse_decoder #(
  parameter int unsigned ID              = 1,
  parameter int unsigned CLK_PER_US      = 50,
  parameter int unsigned SWEEP_MAX_US    = 50,
  parameter int unsigned SYNC_GAP_US     = 500,
  parameter int unsigned SWEEP_WINDOW_US = 8333,
  parameter int unsigned TIMEOUT_US      = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor,
  output logic [31:0] sensor_value,
  output logic        data_available,
  output logic        sample_valid,
  output logic [31:0] ootx_a,
  output logic [31:0] ootx_b
);

  localparam int unsigned PRE_W       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned WIDTH_W     = 10;
  localparam int unsigned D_W         = 20;
  localparam int unsigned SYNC_MIN_US = 57;
  localparam int unsigned SYNC_MAX_US = 140;
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [WIDTH_W-1:0] WIDTH_SAT = '1;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    SYNCED    = 1'b1
  } state_t;

  logic               r_sync1, r_sync2, r_sync3;
  logic [PRE_W-1:0]   r_presc;
  logic [31:0]        r_now;
  logic [31:0]        r_t_rise;
  logic               r_active;
  logic [WIDTH_W-1:0] r_width;
  logic [31:0]        r_t_last_sync;
  logic               r_have_sync;
  logic [31:0]        r_t_sync;
  logic               r_axis;
  logic               r_lh;
  logic               r_data;
  logic [31:0]        r_t_last_sample;
  state_t             r_state;

  logic               w_rise, w_fall, w_tick, w_pulse_end;
  logic [31:0]        w_width32;
  logic               w_is_sweep, w_is_sync;
  logic [2:0]         w_code;
  logic               w_skip, w_idx;
  logic [D_W-1:0]     w_d;
  logic               w_d_ok, w_window_expired, w_timed_out;
  state_t             w_state_nxt;
  logic               w_emit;

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_fall      = ~r_sync2 & r_sync3;
  assign w_tick      = (r_presc == PRE_LAST);
  assign w_pulse_end = w_fall & r_active;

  assign w_width32  = 32'(r_width);
  assign w_is_sweep = (w_width32 < SWEEP_MAX_US);
  assign w_is_sync  = (w_width32 >= SYNC_MIN_US) && (w_width32 <= SYNC_MAX_US);
  assign w_skip     = w_code[2];
  // First sync after reset has no predecessor, so it is always the first of a pair
  assign w_idx      = r_have_sync && ((r_t_rise - r_t_last_sync) < SYNC_GAP_US);

  assign w_d              = D_W'(r_t_rise - r_t_sync) + D_W'(r_width >> 1);
  assign w_d_ok           = (32'(w_d) <= SWEEP_WINDOW_US);
  assign w_window_expired = ((r_now - r_t_sync) > SWEEP_WINDOW_US);
  assign w_timed_out      = ((r_now - r_t_last_sample) >= TIMEOUT_US);

  // Sync code = number of width thresholds the pulse reaches
  always_comb begin
    w_code = 3'd0;
    if      (w_width32 >= 32'd130) w_code = 3'd7;
    else if (w_width32 >= 32'd120) w_code = 3'd6;
    else if (w_width32 >= 32'd109) w_code = 3'd5;
    else if (w_width32 >= 32'd99)  w_code = 3'd4;
    else if (w_width32 >= 32'd89)  w_code = 3'd3;
    else if (w_width32 >= 32'd78)  w_code = 3'd2;
    else if (w_width32 >= 32'd68)  w_code = 3'd1;
  end

  // Input synchroniser; reset to "light" so a pulse straddling reset yields no rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= sensor;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Microsecond prescaler and free-running timestamp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_now   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_now   <= r_now + 32'd1;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Pulse width measurement; the rise cycle itself counts as a high cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_t_rise <= '0;
      r_active <= 1'b0;
      r_width  <= '0;
    end else if (w_rise) begin
      r_t_rise <= r_now;
      r_active <= 1'b1;
      r_width  <= w_tick ? WIDTH_W'(1) : '0;
    end else if (w_pulse_end) begin
      r_active <= 1'b0;
    end else if (r_active && r_sync2 && w_tick && (r_width != WIDTH_SAT)) begin
      r_width <= r_width + WIDTH_W'(1);
    end
  end

  // Sync bookkeeping: every valid sync updates the pair reference, non-skip syncs the sweep reference
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_t_last_sync <= '0;
      r_have_sync   <= 1'b0;
      r_t_sync      <= '0;
      r_axis        <= 1'b0;
      r_lh          <= 1'b0;
      r_data        <= 1'b0;
    end else if (w_pulse_end && w_is_sync) begin
      r_t_last_sync <= r_t_rise;
      r_have_sync   <= 1'b1;
      if (!w_skip) begin
        r_t_sync <= r_t_rise;
        r_axis   <= w_code[0];
        r_data   <= w_code[1];
        r_lh     <= w_idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT_SYNC;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and sample-emit decision
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    if (w_pulse_end) begin
      if (w_is_sweep) begin
        w_emit = (r_state == SYNCED) && w_d_ok;
      end else if (w_is_sync) begin
        if (!w_skip) w_state_nxt = SYNCED;
      end else begin
        w_state_nxt = WAIT_SYNC;
      end
    end else if ((r_state == SYNCED) && w_window_expired) begin
      w_state_nxt = WAIT_SYNC;
    end
  end

  // Sample output register and tracking flag; a new sample beats the timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sensor_value    <= '0;
      sample_valid    <= 1'b0;
      data_available  <= 1'b0;
      r_t_last_sample <= '0;
    end else begin
      sample_valid <= w_emit;
      if (w_emit) begin
        sensor_value    <= {8'(ID), 1'b0, r_data, r_lh, r_axis, w_d};
        data_available  <= 1'b1;
        r_t_last_sample <= r_now;
      end else if (w_timed_out) begin
        data_available <= 1'b0;
      end
    end
  end

`ifdef LIGHTHOUSE_OOTX_EN
  // OOTX data bits from every valid sync, split by lighthouse index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ootx_a <= '0;
      ootx_b <= '0;
    end else if (w_pulse_end && w_is_sync) begin
      if (w_idx) ootx_b <= {ootx_b[30:0], w_code[1]};
      else       ootx_a <= {ootx_a[30:0], w_code[1]};
    end
  end
`else
  assign ootx_a = '0;
  assign ootx_b = '0;
`endif

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Directed bench for lighthouse_pulse_decoder, scaled time base (2 clk per us).
module tb_lighthouse_pulse_decoder;

  localparam int unsigned P = 2;

`ifdef LIGHTHOUSE_OOTX_EN
  localparam logic [31:0] EXP_OOTX_A = 32'h0000_0007;
  localparam logic [31:0] EXP_OOTX_B = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_OOTX_A = 32'h0;
  localparam logic [31:0] EXP_OOTX_B = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sensor;
  logic [31:0] sensor_value;
  logic        data_available;
  logic        sample_valid;
  logic [31:0] ootx_a;
  logic [31:0] ootx_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int sv_count     = 0;
  logic [31:0] last_sample = '0;

  lighthouse_pulse_decoder #(
    .ID(1), .CLK_PER_US(P), .SWEEP_MAX_US(50), .SYNC_GAP_US(500),
    .SWEEP_WINDOW_US(8333), .TIMEOUT_US(2000)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor),
    .sensor_value(sensor_value), .data_available(data_available),
    .sample_valid(sample_valid), .ootx_a(ootx_a), .ootx_b(ootx_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      sv_count    = sv_count + 1;
      last_sample = sensor_value;
    end
  end

  task automatic drive(input logic level, input int us);
    sensor = level;
    repeat (us * P) @(negedge clk);
  endtask

  task automatic apply_reset();
    sensor = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int c0;
    apply_reset();
    drive(1'b0, 5);
    drive(1'b1, 20);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    c0 = sv_count;
    drive(1'b1, 20);
    drive(1'b0, 20);
    tests_run++;
    if ((sv_count - c0) !== 0) begin tests_failed++; $display("FAIL reset_strobe: got %0d strobes, expected 0", sv_count - c0); end
    tests_run++;
    if (sensor_value !== 32'h0) begin tests_failed++; $display("FAIL reset_value: got %h, expected 00000000", sensor_value); end
    tests_run++;
    if (data_available !== 1'b0) begin tests_failed++; $display("FAIL reset_da: got %b, expected 0", data_available); end
    tests_run++;
    if (ootx_a !== 32'h0 || ootx_b !== 32'h0) begin tests_failed++; $display("FAIL reset_ootx: got %h/%h, expected 0/0", ootx_a, ootx_b); end
  endtask

  task automatic test_basic_sweep();
    int c0;
    logic [31:0] exp;
    exp = {8'd1, 4'b0001, 20'd4005};
    apply_reset();
    drive(1'b0, 10);
    c0 = sv_count;
    drive(1'b1, 73);
    drive(1'b0, 4000 - 73);
    drive(1'b1, 10);
    sensor = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: got %b, expected 0", sample_valid); end
    @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b1) begin tests_failed++; $display("FAIL latency_hit: got %b, expected 1", sample_valid); end
    @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL strobe_len: got %b, expected 0", sample_valid); end
    drive(1'b0, 5);
    tests_run++;
    if ((sv_count - c0) !== 1) begin tests_failed++; $display("FAIL basic_count: got %0d, expected 1", sv_count - c0); end
    tests_run++;
    if (last_sample !== exp || sensor_value !== exp) begin tests_failed++; $display("FAIL basic_value: got %h/%h, expected %h", last_sample, sensor_value, exp); end
    tests_run++;
    if (data_available !== 1'b1) begin tests_failed++; $display("FAIL basic_da: got %b, expected 1", data_available); end
  endtask

  task automatic test_skip_pair();
    int c0;
    logic [31:0] exp;
    exp = {8'd1, 4'b0010, 20'd2004};
    apply_reset();
    drive(1'b0, 10);
    c0 = sv_count;
    drive(1'b1, 104);
    drive(1'b0, 400 - 104);
    drive(1'b1, 63);
    drive(1'b0, 2000 - 63);
    drive(1'b1, 8);
    drive(1'b0, 10);
    tests_run++;
    if ((sv_count - c0) !== 1) begin tests_failed++; $display("FAIL pair_count: got %0d, expected 1", sv_count - c0); end
    tests_run++;
    if (last_sample !== exp) begin tests_failed++; $display("FAIL pair_value: got %h, expected %h", last_sample, exp); end
  endtask

  task automatic test_no_sync();
    int c0;
    apply_reset();
    drive(1'b0, 10);
    c0 = sv_count;
    drive(1'b1, 10);
    drive(1'b0, 50);
    tests_run++;
    if ((sv_count - c0) !== 0) begin tests_failed++; $display("FAIL nosync_sweep: got %0d, expected 0", sv_count - c0); end
    drive(1'b1, 200);
    drive(1'b0, 100);
    drive(1'b1, 10);
    drive(1'b0, 20);
    tests_run++;
    if ((sv_count - c0) !== 0) begin tests_failed++; $display("FAIL nosync_long: got %0d, expected 0", sv_count - c0); end
    drive(1'b1, 73);
    drive(1'b0, 300 - 73);
    drive(1'b1, 200);
    drive(1'b0, 300);
    drive(1'b1, 10);
    drive(1'b0, 20);
    tests_run++;
    if ((sv_count - c0) !== 0) begin tests_failed++; $display("FAIL invalid_resync: got %0d, expected 0", sv_count - c0); end
  endtask

  task automatic test_width_boundary();
    int c0;
    logic [31:0] exp;
    exp = {8'd1, 4'b0001, 20'd1024};
    apply_reset();
    drive(1'b0, 10);
    c0 = sv_count;
    drive(1'b1, 73);
    drive(1'b0, 1000 - 73);
    drive(1'b1, 49);
    drive(1'b0, 1000 - 49);
    tests_run++;
    if ((sv_count - c0) !== 1) begin tests_failed++; $display("FAIL w49_count: got %0d, expected 1", sv_count - c0); end
    tests_run++;
    if (last_sample !== exp) begin tests_failed++; $display("FAIL w49_value: got %h, expected %h", last_sample, exp); end
    c0 = sv_count;
    drive(1'b1, 50);
    drive(1'b0, 1000 - 50);
    drive(1'b1, 10);
    drive(1'b0, 20);
    tests_run++;
    if ((sv_count - c0) !== 0) begin tests_failed++; $display("FAIL w50_drop: got %0d, expected 0", sv_count - c0); end
  endtask

  task automatic test_timeout();
    int c0;
    logic [31:0] exp;
    exp = {8'd1, 4'b0001, 20'd1005};
    apply_reset();
    drive(1'b0, 10);
    c0 = sv_count;
    drive(1'b1, 73);
    drive(1'b0, 1000 - 73);
    drive(1'b1, 10);
    drive(1'b0, 1880);
    tests_run++;
    if ((sv_count - c0) !== 1 || last_sample !== exp) begin tests_failed++; $display("FAIL to_sample: got %0d/%h, expected 1/%h", sv_count - c0, last_sample, exp); end
    tests_run++;
    if (data_available !== 1'b1) begin tests_failed++; $display("FAIL to_before: got %b, expected 1", data_available); end
    drive(1'b0, 220);
    tests_run++;
    if (data_available !== 1'b0) begin tests_failed++; $display("FAIL to_after: got %b, expected 0", data_available); end
    c0 = sv_count;
    drive(1'b0, 9000 - 3110);
    drive(1'b1, 10);
    drive(1'b0, 10);
    tests_run++;
    if ((sv_count - c0) !== 0) begin tests_failed++; $display("FAIL window_drop: got %0d, expected 0", sv_count - c0); end
    tests_run++;
    if (sensor_value !== exp || data_available !== 1'b0) begin tests_failed++; $display("FAIL hold_value: got %h/%b, expected %h/0", sensor_value, data_available, exp); end
  endtask

  task automatic test_ootx();
    apply_reset();
    drive(1'b0, 10);
    drive(1'b1, 83);
    drive(1'b0, 600 - 83);
    drive(1'b1, 94);
    drive(1'b0, 600 - 94);
    drive(1'b1, 83);
    drive(1'b0, 300 - 83);
    drive(1'b1, 94);
    drive(1'b0, 20);
    tests_run++;
    if (ootx_a !== EXP_OOTX_A) begin tests_failed++; $display("FAIL ootx_a: got %h, expected %h", ootx_a, EXP_OOTX_A); end
    tests_run++;
    if (ootx_b !== EXP_OOTX_B) begin tests_failed++; $display("FAIL ootx_b: got %h, expected %h", ootx_b, EXP_OOTX_B); end
  endtask

  initial begin
    reset  = 1'b1;
    sensor = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_sweep();
    test_skip_pair();
    test_no_sync();
    test_width_boundary();
    test_timeout();
    test_ootx();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
